// File: rtl/cordic_arbiter_if.sv
// ---------------------------------------------------------------------------
// cordic_arbiter_if : requester and CORDIC-core signals around cordic_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cordic_arbiter_if #(
  parameter int IO_WIDTH = 18,
  parameter int REQ_NUM  = 3
);
  logic [REQ_NUM-1:0]          req_i;
  logic [REQ_NUM*IO_WIDTH-1:0] x_i;
  logic [REQ_NUM*IO_WIDTH-1:0] y_i;
  logic [REQ_NUM*IO_WIDTH-1:0] theta_i;
  logic [REQ_NUM-1:0]          gnt_o;
  logic [REQ_NUM-1:0]          rsp_valid_o;
  logic [IO_WIDTH-1:0]         x_o;
  logic [IO_WIDTH-1:0]         y_o;
  logic [IO_WIDTH-1:0]         theta_o;
  logic                        err_o;
  logic                        cor_start_o;
  logic [IO_WIDTH-1:0]         cor_x_o;
  logic [IO_WIDTH-1:0]         cor_y_o;
  logic [IO_WIDTH-1:0]         cor_theta_o;
  logic                        cor_done_i;
  logic [IO_WIDTH-1:0]         cor_x_i;
  logic [IO_WIDTH-1:0]         cor_y_i;
  logic [IO_WIDTH-1:0]         cor_theta_i;

  // Arbiter side
  modport slave (
    input  req_i, x_i, y_i, theta_i, cor_done_i, cor_x_i, cor_y_i, cor_theta_i,
    output gnt_o, rsp_valid_o, x_o, y_o, theta_o, err_o,
           cor_start_o, cor_x_o, cor_y_o, cor_theta_o
  );

  // Requester / core side
  modport master (
    output req_i, x_i, y_i, theta_i, cor_done_i, cor_x_i, cor_y_i, cor_theta_i,
    input  gnt_o, rsp_valid_o, x_o, y_o, theta_o, err_o,
           cor_start_o, cor_x_o, cor_y_o, cor_theta_o
  );
endinterface

`default_nettype wire

// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter : round-robin sharing of one CORDIC core, with watchdog abort
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_arbiter #(
  parameter int IO_WIDTH = 18,
  parameter int REQ_NUM  = 3,
  parameter int TIMEOUT  = 31
) (
  input  logic             sys_clk_i,
  input  logic             reset_i,
  cordic_arbiter_if.slave  bus
);

  localparam int c_IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TMO      = c_CNT_W'(TIMEOUT);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(REQ_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [REQ_NUM-1:0]  r_gnt, w_gnt_nxt;
  logic [c_IDX_W-1:0]  r_last, w_last_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
  logic [IO_WIDTH-1:0] r_cor_x, r_cor_y, r_cor_t;
  logic [IO_WIDTH-1:0] w_cor_x_nxt, w_cor_y_nxt, w_cor_t_nxt;
  logic [IO_WIDTH-1:0] r_x, r_y, r_t;
  logic [IO_WIDTH-1:0] w_x_nxt, w_y_nxt, w_t_nxt;
  logic                w_start;
  logic [REQ_NUM-1:0]  w_rsp;
  logic                w_err_out;
  logic                w_any;
  logic [c_IDX_W-1:0]  w_win;
  int                  w_n;

  // Descending scan so the nearest requester after r_last is written last and wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_n   = 0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      w_n = int'(r_last) + k;
      if (w_n >= REQ_NUM) w_n = w_n - REQ_NUM;
      if (bus.req_i[w_n[c_IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_n[c_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_cor_x_nxt = r_cor_x;
    w_cor_y_nxt = r_cor_y;
    w_cor_t_nxt = r_cor_t;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_t_nxt     = r_t;
    w_start     = 1'b0;
    w_rsp       = '0;
    w_err_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_last_nxt       = w_win;
          w_cor_x_nxt      = bus.x_i[int'(w_win)*IO_WIDTH +: IO_WIDTH];
          w_cor_y_nxt      = bus.y_i[int'(w_win)*IO_WIDTH +: IO_WIDTH];
          w_cor_t_nxt      = bus.theta_i[int'(w_win)*IO_WIDTH +: IO_WIDTH];
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done in the final watchdog cycle still takes precedence
        if (bus.cor_done_i) begin
          w_x_nxt     = bus.cor_x_i;
          w_y_nxt     = bus.cor_y_i;
          w_t_nxt     = bus.cor_theta_i;
          w_state_nxt = S_RESP;
        end else if (r_cnt == c_TMO) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_t_nxt     = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        w_rsp       = r_gnt;
        w_err_out   = r_err;
        w_gnt_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_cor_x <= '0;
      r_cor_y <= '0;
      r_cor_t <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_cor_x <= w_cor_x_nxt;
      r_cor_y <= w_cor_y_nxt;
      r_cor_t <= w_cor_t_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_t     <= w_t_nxt;
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.rsp_valid_o = w_rsp;
  assign bus.err_o       = w_err_out;
  assign bus.x_o         = r_x;
  assign bus.y_o         = r_y;
  assign bus.theta_o     = r_t;
  assign bus.cor_start_o = w_start;
  assign bus.cor_x_o     = r_cor_x;
  assign bus.cor_y_o     = r_cor_y;
  assign bus.cor_theta_o = r_cor_t;

endmodule

`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cordic_arbiter : directed + randomized self-checking bench for cordic_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cordic_arbiter;

  localparam int W   = 18;
  localparam int N   = 3;
  localparam int TMO = 31;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  int          m_last;
  logic [W-1:0] m_xo, m_yo, m_to;

  cordic_arbiter_if #(.IO_WIDTH(W), .REQ_NUM(N)) bus ();

  cordic_arbiter #(.IO_WIDTH(W), .REQ_NUM(N), .TIMEOUT(TMO)) dut (
    .sys_clk_i (clk),
    .reset_i   (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first set request after the last winner, wrapping
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic rand_operands();
    for (int n = 0; n < N; n++) begin
      bus.x_i[n*W +: W]     = W'($urandom);
      bus.y_i[n*W +: W]     = W'($urandom);
      bus.theta_i[n*W +: W] = W'($urandom);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp"},   64'(bus.rsp_valid_o), 64'd0);
    check({tag, "_err"},   64'(bus.err_o),       64'd0);
    check({tag, "_start"}, 64'(bus.cor_start_o), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    tick();
    check("rst_gnt",   64'(bus.gnt_o),       64'd0);
    check("rst_x",     64'(bus.x_o),         64'd0);
    check("rst_y",     64'(bus.y_o),         64'd0);
    check("rst_theta", 64'(bus.theta_o),     64'd0);
    check("rst_corx",  64'(bus.cor_x_o),     64'd0);
    check("rst_cory",  64'(bus.cor_y_o),     64'd0);
    check("rst_cort",  64'(bus.cor_theta_o), 64'd0);
    check_idle_outputs("rst");
    rst = 1'b0;
    m_last = N - 1;
    m_xo = '0; m_yo = '0; m_to = '0;
  endtask

  // Caller is in an IDLE cycle with req_i already set. lat = cycles from start
  // to done (1..TMO+1), 0 = core never answers. drop_at = cycle in which the
  // winner lowers its request (0 = never). fx/fy/ft fixed results if use_fixed.
  task automatic run_op(input int lat, input int drop_at, input bit use_fixed,
                        input logic [W-1:0] fx, input logic [W-1:0] fy, input logic [W-1:0] ft);
    int win;
    int last_wait;
    bit tmo;
    logic [W-1:0] ex, ey, et, rx, ry, rt;
    win = pick(bus.req_i, m_last);
    m_last = win;
    ex = bus.x_i[win*W +: W];
    ey = bus.y_i[win*W +: W];
    et = bus.theta_i[win*W +: W];
    tmo = (lat == 0);
    last_wait = tmo ? (TMO + 2) : (lat + 1);
    rx = use_fixed ? fx : W'($urandom);
    ry = use_fixed ? fy : W'($urandom);
    rt = use_fixed ? ft : W'($urandom);
    // Stray done during IDLE and ISSUE must be ignored
    bus.cor_done_i = 1'b1;
    bus.cor_x_i = W'($urandom); bus.cor_y_i = W'($urandom); bus.cor_theta_i = W'($urandom);
    tick();
    check("issue_gnt",   64'(bus.gnt_o),       64'(1) << win);
    check("issue_start", 64'(bus.cor_start_o), 64'd1);
    check("issue_corx",  64'(bus.cor_x_o),     64'(ex));
    check("issue_cory",  64'(bus.cor_y_o),     64'(ey));
    check("issue_cort",  64'(bus.cor_theta_o), 64'(et));
    check("issue_rsp",   64'(bus.rsp_valid_o), 64'd0);
    check("held_x",      64'(bus.x_o),         64'(m_xo));
    rand_operands();
    for (int c = 2; c <= last_wait; c++) begin
      tick();
      bus.cor_done_i = 1'b0;
      if (c == drop_at) bus.req_i[win] = 1'b0;
      if (c == last_wait) begin
        check("wait_start", 64'(bus.cor_start_o), 64'd0);
        check("wait_rsp",   64'(bus.rsp_valid_o), 64'd0);
        check("wait_corx",  64'(bus.cor_x_o),     64'(ex));
        check("wait_cort",  64'(bus.cor_theta_o), 64'(et));
        if (!tmo) begin
          bus.cor_done_i  = 1'b1;
          bus.cor_x_i     = rx;
          bus.cor_y_i     = ry;
          bus.cor_theta_i = rt;
        end
      end
    end
    tick();
    bus.cor_done_i = 1'b0;
    if (tmo) begin
      m_xo = '0; m_yo = '0; m_to = '0;
    end else begin
      m_xo = rx; m_yo = ry; m_to = rt;
    end
    check("resp_valid", 64'(bus.rsp_valid_o), 64'(1) << win);
    check("resp_err",   64'(bus.err_o),       64'(tmo));
    check("resp_x",     64'(bus.x_o),         64'(m_xo));
    check("resp_y",     64'(bus.y_o),         64'(m_yo));
    check("resp_theta", 64'(bus.theta_o),     64'(m_to));
    tick();
    check("post_gnt", 64'(bus.gnt_o), 64'd0);
    check_idle_outputs("post");
    check("post_x", 64'(bus.x_o), 64'(m_xo));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req_i = '0;
    bus.x_i = '0; bus.y_i = '0; bus.theta_i = '0;
    bus.cor_done_i = 1'b0;
    bus.cor_x_i = '0; bus.cor_y_i = '0; bus.cor_theta_i = '0;
    tick();
    do_reset();

    // Single request with fixed operands and results, latency 16
    rand_operands();
    bus.x_i[0 +: W] = 18'h04000;
    bus.y_i[0 +: W] = 18'h02000;
    bus.req_i = 3'b001;
    run_op(16, 0, 1'b1, 18'h01234, 18'h00000, 18'h00abc);
    bus.req_i = '0;
    tick();

    // Contention: all requesters held, grants rotate
    do_reset();
    bus.req_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      rand_operands();
      run_op($urandom_range(1, 20), 0, 1'b0, '0, '0, '0);
    end
    bus.req_i = '0;

    // Priority after reset
    do_reset();
    bus.req_i = 3'b110;
    rand_operands();
    run_op(16, 0, 1'b0, '0, '0, '0);
    rand_operands();
    run_op(16, 0, 1'b0, '0, '0, '0);
    bus.req_i = '0;

    // Watchdog abort, then normal service, then done in the final WAIT cycle
    bus.req_i = 3'b010;
    rand_operands();
    run_op(0, 0, 1'b0, '0, '0, '0);
    rand_operands();
    run_op(16, 0, 1'b0, '0, '0, '0);
    rand_operands();
    run_op(TMO + 1, 0, 1'b0, '0, '0, '0);
    bus.req_i = '0;

    // Stray done in IDLE
    bus.cor_done_i = 1'b1;
    bus.cor_x_i = W'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stray_gnt", 64'(bus.gnt_o), 64'd0);
      check_idle_outputs("stray");
      check("stray_x", 64'(bus.x_o), 64'(m_xo));
    end
    bus.cor_done_i = 1'b0;

    // Request dropped mid-WAIT
    bus.req_i = 3'b100;
    rand_operands();
    run_op(16, 6, 1'b0, '0, '0, '0);
    check("drop_req", 64'(bus.req_i), 64'd0);
    tick();
    check("drop_no_second", 64'(bus.rsp_valid_o), 64'd0);

    // Reset mid-WAIT aborts with no response
    bus.req_i = 3'b001;
    rand_operands();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
    do_reset();
    bus.req_i = 3'b100;
    rand_operands();
    run_op(12, 0, 1'b0, '0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 12; i++) begin
      bus.req_i = N'($urandom_range(1, (1 << N) - 1));
      rand_operands();
      run_op(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMO + 1)), 0, 1'b0, '0, '0, '0);
    end
    bus.req_i = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter and sequencer that shares one CORDIC core between several FOC requesters (e.g. Park, inverse Park, magnitude/phase). It latches the winning requester's operands, issues a one-cycle start to the core and waits for its done. It then returns the core's results to that requester with a one-cycle valid pulse. A watchdog aborts any operation whose done never arrives.

## Interface
- IO_WIDTH, 18, width of every operand and result
- REQ_NUM, 3, number of requesters (2..8)
- TIMEOUT, 31, maximum WAIT cycles before abort (must exceed core latency, 16 for ITER_NUM=15)
- sys_clk_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  REQ_NUM  per-requester request level; held until its rsp_valid_o bit
- x_i / y_i / theta_i  in  REQ_NUM*IO_WIDTH each  packed operands; requester n at [n*IO_WIDTH +: IO_WIDTH]
- gnt_o  out  REQ_NUM  one-hot grant, registered
- rsp_valid_o  out  REQ_NUM  one-hot, one-cycle result-valid pulse
- x_o / y_o / theta_o  out  IO_WIDTH each  signed results, shared bus, qualified by rsp_valid_o
- err_o  out  1  one-cycle pulse coincident with rsp_valid_o when the operation timed out
- cor_start_o  out  1  one-cycle start to the core
- cor_x_o / cor_y_o / cor_theta_o  out  IO_WIDTH each  operands to the core, stable from ISSUE through WAIT
- cor_done_i  in  1  core done pulse
- cor_x_i / cor_y_i / cor_theta_i  in  IO_WIDTH each  core results, valid with cor_done_i

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_i bit set:
  - Pick the first set bit scanning upward (with wrap) from last_gnt+1.
  - Register gnt_o, capture that requester's operands into cor_*_o, store the index in last_gnt.
  - Go to ISSUE.
- IDLE, no request: stay in IDLE.
- ISSUE: cor_start_o=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT, cor_done_i=1:
  - Capture cor_x_i/cor_y_i/cor_theta_i into x_o/y_o/theta_o.
  - Go to RESP.
- WAIT, no done: increment the counter.
  - When the counter reaches TIMEOUT: set x_o/y_o/theta_o to 0, set the error flag, go to RESP.
- RESP:
  - rsp_valid_o = gnt_o for one cycle; err_o = error flag.
  - Clear gnt_o and the error flag; go to IDLE.
- Ordering and arbitration:
  - Results are stored as received, with no reinterpretation.
  - last_gnt resets to REQ_NUM-1, so requester 0 has the highest priority after reset.
  - Fairness: with every requester continuously asserted, grants rotate 0,1,2,0,...
- cor_done_i outside WAIT is ignored.
- Requester drops req_i while granted: the operation still completes and the response pulse is still issued. This is not an error.
- req_i still set in the IDLE cycle after RESP is a new request.
- A request arriving during ISSUE/WAIT/RESP waits for the next IDLE arbitration. It is never lost, provided the requester holds req_i.

## Timing
- Reset (synchronous, takes effect on the next edge):
  - State returns to IDLE.
  - gnt_o, rsp_valid_o, err_o, cor_start_o, x_o, y_o, theta_o, cor_x_o, cor_y_o, cor_theta_o all become 0.
  - The counter clears and last_gnt = REQ_NUM-1.
  - Reset in any state aborts the operation and issues no response.
- Request sampled in IDLE at edge 0:
  - gnt_o and cor_*_o valid in cycle 1 (ISSUE), with cor_start_o=1 in cycle 1.
  - WAIT from cycle 2.
- cor_done_i sampled high in cycle k: rsp_valid_o, x_o, y_o, theta_o valid in cycle k+1 (RESP); IDLE in cycle k+2.
- Back-to-back operations: minimum period = core latency + 3 cycles.
- x_o/y_o/theta_o hold their values until the next RESP or reset.
- Timeout: RESP occurs TIMEOUT+1 cycles after entering WAIT if no done is seen. A done arriving in that same final WAIT cycle wins, with no error.

## Test plan
- Single request: reset, req_i=3'b001, x=18'h04000, y=18'h02000; core model returns done after 16 cycles with x=18'h1234, y=0, theta=18'h0abc.
  - Required: cor_start_o in cycle 1; rsp_valid_o=001 with those values exactly 17 cycles after ISSUE; err_o=0.
- Contention: req_i=3'b111 held continuously.
  - Required: grants 001,010,100,001; each requester sees its own operands on cor_*_o.
- Priority after reset: req_i=3'b110.
  - Required: first grant 010, second grant 100.
- Timeout: core never asserts done.
  - Required: rsp_valid_o pulse, err_o=1 and x_o=y_o=theta_o=0 at WAIT+TIMEOUT+1; next request then serviced normally.
- Stray and dropped signals:
  - Stray cor_done_i during IDLE: no response.
  - req_i dropped mid-WAIT: response still pulsed once.
- Reset mid-WAIT: no rsp_valid_o; all outputs 0; next req_i=3'b100 gets grant 100 within 1 cycle.
